// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// id_ex_stage : RISC-V decode stage and ID/EX pipeline register. Handles
//   operand select, immediates, load-use stall and EX flush. Define
//   WB_BYPASS_EN to forward same-cycle writeback data into the operands.
// Revision : 1.0
// ============================================================================
module id_ex_stage #(
  parameter int SIZE = 32,
  parameter int NREG = 32,
  localparam int A = $clog2(NREG)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [SIZE-1:0] if_pc,
  output logic [A-1:0]    reg1r,
  output logic [A-1:0]    reg2r,
  input  logic [SIZE-1:0] Data1,
  input  logic [SIZE-1:0] Data2,
  input  logic [A-1:0]    wb_regW,
  input  logic [SIZE-1:0] wb_writeData,
  input  logic            wb_RegWrite,
  input  logic            ex_ready,
  input  logic            flush,
  output logic            stall,
  output logic            ex_valid,
  output logic [SIZE-1:0] ex_pc,
  output logic [SIZE-1:0] ex_rs1_data,
  output logic [SIZE-1:0] ex_rs2_data,
  output logic [SIZE-1:0] ex_imm,
  output logic [A-1:0]    ex_rs1,
  output logic [A-1:0]    ex_rs2,
  output logic [A-1:0]    ex_rd,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [6:0]         opcode;
  logic [A-1:0]       rs1_idx, rs2_idx, rd_idx;
  logic               rs1_used, rs2_used, lu;
  logic signed [31:0] imm32;
  logic [SIZE-1:0]    op1, op2;

  logic            valid_q, valid_d;
  logic [SIZE-1:0] pc_q, pc_d, rs1d_q, rs1d_d, rs2d_q, rs2d_d, imm_q, imm_d;
  logic [A-1:0]    rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [6:0]      opc_q, opc_d;
  logic [2:0]      f3_q, f3_d;
  logic            f7_q, f7_d;

  assign opcode  = if_instr[6:0];
  assign rs1_idx = if_instr[15 +: A];
  assign rs2_idx = if_instr[20 +: A];
  assign rd_idx  = if_instr[7 +: A];
  assign reg1r   = rs1_idx;
  assign reg2r   = rs2_idx;

  // Register file returns old data on read-during-write, hence the bypass.
  function automatic logic [SIZE-1:0] sel_operand(input logic [A-1:0] idx,
                                                  input logic [SIZE-1:0] rf);
    if (idx == '0) return '0;
`ifdef WB_BYPASS_EN
    if (wb_RegWrite && (wb_regW != '0) && (wb_regW == idx)) return wb_writeData;
`endif
    return rf;
  endfunction

`ifndef WB_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{wb_regW, wb_writeData, wb_RegWrite};
`endif

  assign op1 = sel_operand(rs1_idx, Data1);
  assign op2 = sel_operand(rs2_idx, Data2);

  always_comb begin
    imm32 = '0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
      OP_STORE:  imm32 = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
      OP_BRANCH: imm32 = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                          if_instr[30:25], if_instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm32 = {if_instr[31:12], 12'b0};
      OP_JAL:    imm32 = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                          if_instr[20], if_instr[30:21], 1'b0};
      default:   imm32 = '0;
    endcase
  end

  assign rs1_used = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
  assign rs2_used = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

  assign lu = valid_q && (opc_q == OP_LOAD) && (rd_q != '0) && if_valid &&
              ((rs1_used && (rs1_idx == rd_q)) || (rs2_used && (rs2_idx == rd_q)));

  assign stall = if_valid && (!ex_ready || lu) && !flush && !RESET;

  always_comb begin
    valid_d = valid_q;  pc_d  = pc_q;  rs1d_d = rs1d_q;  rs2d_d = rs2d_q;
    imm_d   = imm_q;    rs1_d = rs1_q; rs2_d  = rs2_q;   rd_d   = rd_q;
    opc_d   = opc_q;    f3_d  = f3_q;  f7_d   = f7_q;
    if (flush || (ex_ready && (lu || !if_valid))) begin
      valid_d = 1'b0;  pc_d  = '0;  rs1d_d = '0;  rs2d_d = '0;
      imm_d   = '0;    rs1_d = '0;  rs2_d  = '0;  rd_d   = '0;
      opc_d   = '0;    f3_d  = '0;  f7_d   = 1'b0;
    end else if (ex_ready) begin
      valid_d = 1'b1;              pc_d  = if_pc;
      rs1d_d  = op1;               rs2d_d = op2;
      imm_d   = SIZE'(imm32);      rs1_d = rs1_idx;
      rs2_d   = rs2_idx;           rd_d  = rd_idx;
      opc_d   = opcode;            f3_d  = if_instr[14:12];
      f7_d    = if_instr[30];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= 1'b0;  pc_q  <= '0;  rs1d_q <= '0;  rs2d_q <= '0;
      imm_q   <= '0;    rs1_q <= '0;  rs2_q  <= '0;  rd_q   <= '0;
      opc_q   <= '0;    f3_q  <= '0;  f7_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;  pc_q  <= pc_d;   rs1d_q <= rs1d_d;  rs2d_q <= rs2d_d;
      imm_q   <= imm_d;    rs1_q <= rs1_d;  rs2_q  <= rs2_d;   rd_q   <= rd_d;
      opc_q   <= opc_d;    f3_q  <= f3_d;   f7_q   <= f7_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_pc       = pc_q;
  assign ex_rs1_data = rs1d_q;
  assign ex_rs2_data = rs2d_q;
  assign ex_imm      = imm_q;
  assign ex_rs1      = rs1_q;
  assign ex_rs2      = rs2_q;
  assign ex_rd       = rd_q;
  assign ex_opcode   = opc_q;
  assign ex_funct3   = f3_q;
  assign ex_funct7b5 = f7_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// tb_id_ex_stage : directed + random stimulus with a queued reference model
//   of the ID/EX boundary.
// Revision : 1.0
// ============================================================================
module tb_id_ex_stage;
  localparam int SIZE = 32;
  localparam int NREG = 32;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_instr = '0, if_pc = '0, Data1 = '0, Data2 = '0, wb_writeData = '0;
  logic [4:0]  wb_regW = '0;
  logic        wb_RegWrite = 1'b0, ex_ready = 1'b1, flush = 1'b0;
  logic [4:0]  reg1r, reg2r, ex_rs1, ex_rs2, ex_rd;
  logic        stall, ex_valid, ex_funct7b5;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;

  id_ex_stage #(.SIZE(SIZE), .NREG(NREG)) dut (
    .CLK(CLK), .RESET(RESET), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .reg1r(reg1r), .reg2r(reg2r), .Data1(Data1), .Data2(Data2),
    .wb_regW(wb_regW), .wb_writeData(wb_writeData), .wb_RegWrite(wb_RegWrite),
    .ex_ready(ex_ready), .flush(flush), .stall(stall), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_opcode(ex_opcode),
    .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        v;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
  } ex_t;

  ex_t exp_q[$];
  ex_t m = '0;
  int  checks = 0, failures = 0;
  bit  last_stall = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic ex_t dut_ex();
    dut_ex = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
              ex_opcode, ex_funct3, ex_funct7b5};
  endfunction

  // Immediates as signed sums of the instruction's fields.
  function automatic logic [31:0] imm_of(input logic [31:0] i);
    int v;
    case (i[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: v = i[30:20] - i[31] * 2048;
      7'b0100011: v = i[11:7] + i[30:25] * 32 - i[31] * 2048;
      7'b1100011: v = i[11:8] * 2 + i[30:25] * 32 + i[7] * 2048 - i[31] * 4096;
      7'b0110111, 7'b0010111: v = i[31:12] * 4096;
      7'b1101111: v = i[30:21] * 2 + i[20] * 2048 + i[19:12] * 4096 - i[31] * 1048576;
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic bit uses1(input logic [6:0] op);
    return !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
  endfunction

  function automatic bit uses2(input logic [6:0] op);
    return op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] data,
                                          input logic [4:0] wr, input logic [31:0] wd,
                                          input logic we);
    if (idx == 0) return 0;
`ifdef WB_BYPASS_EN
    if (we && wr != 0 && wr == idx) return wd;
`endif
    return data;
  endfunction

  task automatic cycle(input bit rst, input bit v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [4:0] wr,
                       input logic [31:0] wd, input bit we, input bit rdy, input bit fl);
    logic [4:0] r1, r2;
    bit   lu, st;
    ex_t  nxt;
    @(negedge CLK);
    RESET = rst; if_valid = v; if_instr = instr; if_pc = pc; Data1 = d1; Data2 = d2;
    wb_regW = wr; wb_writeData = wd; wb_RegWrite = we; ex_ready = rdy; flush = fl;
    #1;
    r1 = instr[19:15];
    r2 = instr[24:20];
    lu = m.v && m.op == 7'b0000011 && m.rd != 0 && v &&
         ((uses1(instr[6:0]) && r1 == m.rd) || (uses2(instr[6:0]) && r2 == m.rd));
    st = !rst && v && (!rdy || lu) && !fl;
    chk("stall", stall, st);
    chk("reg1r", reg1r, r1);
    chk("reg2r", reg2r, r2);
    last_stall = st;
    if (rst || fl)      nxt = '0;
    else if (!rdy)      nxt = m;
    else if (lu || !v)  nxt = '0;
    else begin
      nxt.v   = 1'b1;  nxt.pc = pc;
      nxt.d1  = operand(r1, d1, wr, wd, we);
      nxt.d2  = operand(r2, d2, wr, wd, we);
      nxt.imm = imm_of(instr);
      nxt.rs1 = r1;  nxt.rs2 = r2;  nxt.rd = instr[11:7];
      nxt.op  = instr[6:0];  nxt.f3 = instr[14:12];  nxt.f7 = instr[30];
    end
    m = nxt;
    exp_q.push_back(nxt);
  endtask

  // Scoreboard monitor: one expected ID/EX snapshot per clock edge.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        ex_t e;
        e = exp_q.pop_front();
        chk("ex_regs", dut_ex(), e);
      end
    end
  end

  task automatic after_edge();
    @(posedge CLK);
    #2;
  endtask

  logic [6:0] ops [10] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011,
                           7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0001111};

  initial begin
    logic [31:0] ri, rpc;
    bit          rv;

    // Reset with inputs that would otherwise raise stall.
    cycle(1, 1, 32'h002303B3, 32'h40, 32'h5, 32'h6, 0, 0, 0, 0, 0);
    cycle(1, 1, 32'h002303B3, 32'h40, 32'h5, 32'h6, 0, 0, 0, 0, 0);
    after_edge();
    chk("reset_ex_valid", ex_valid, 1'b0);
    chk("reset_ex_all", dut_ex(), ex_t'(0));

    // addi x5,x0,-3
    cycle(0, 1, 32'hFFD00293, 32'h100, 32'h1234, 32'h5678, 0, 0, 0, 1, 0);
    after_edge();
    chk("addi_rd", ex_rd, 5'd5);
    chk("addi_imm", ex_imm, 32'hFFFFFFFD);
    chk("addi_rs1_data", ex_rs1_data, 32'h0);

    // lw x6,0(x1) then add x7,x6,x2: one bubble, then capture
    cycle(0, 1, 32'h0000A303, 32'h104, 32'h10, 32'h20, 0, 0, 0, 1, 0);
    cycle(0, 1, 32'h002303B3, 32'h108, 32'h30, 32'h40, 0, 0, 0, 1, 0);
    chk("lu_stall", stall, 1'b1);
    after_edge();
    chk("lu_bubble", ex_valid, 1'b0);
    cycle(0, 1, 32'h002303B3, 32'h108, 32'h30, 32'h40, 0, 0, 0, 1, 0);
    after_edge();
    chk("lu_add_rd", ex_rd, 5'd7);

    // writeback bypass
    cycle(0, 1, 32'h00008193, 32'h10C, 32'h11, 32'h0, 5'd1, 32'hAB, 1, 1, 0);
    after_edge();
`ifdef WB_BYPASS_EN
    chk("bypass_rs1", ex_rs1_data, 32'hAB);
`else
    chk("bypass_rs1", ex_rs1_data, 32'h11);
`endif
    cycle(0, 1, 32'h00000193, 32'h110, 32'h11, 32'h0, 5'd0, 32'hAB, 1, 1, 0);
    after_edge();
    chk("x0_rs1", ex_rs1_data, 32'h0);

    // EX not ready three cycles, flush in the second
    cycle(0, 1, 32'hFFD00293, 32'h114, 32'h1, 32'h2, 0, 0, 0, 1, 0);
    cycle(0, 1, 32'h0000A303, 32'h118, 32'h3, 32'h4, 0, 0, 0, 0, 0);
    after_edge();
    chk("hold_pc", ex_pc, 32'h114);
    cycle(0, 1, 32'h0000A303, 32'h118, 32'h3, 32'h4, 0, 0, 0, 0, 1);
    after_edge();
    chk("flush_valid", ex_valid, 1'b0);
    cycle(0, 1, 32'h0000A303, 32'h11C, 32'h3, 32'h4, 0, 0, 0, 0, 0);

    // RESET mid-hold
    cycle(1, 1, 32'h0000A303, 32'h11C, 32'h3, 32'h4, 0, 0, 0, 0, 0);
    cycle(0, 1, 32'h0000A303, 32'h11C, 32'h3, 32'h4, 0, 0, 0, 1, 0);

    // beq x1,x2,-8 and jal x1,+2048
    cycle(0, 1, 32'hFE208CE3, 32'h200, 32'h7, 32'h8, 0, 0, 0, 1, 0);
    after_edge();
    chk("beq_imm", ex_imm, 32'hFFFFFFF8);
    cycle(0, 1, 32'h001000EF, 32'h204, 32'h7, 32'h8, 0, 0, 0, 1, 0);
    after_edge();
    chk("jal_imm", ex_imm, 32'h00000800);

    // Random traffic; IF/ID holds its instruction while stalled.
    ri = 32'h0; rpc = 32'h0; rv = 1'b0;
    for (int n = 0; n < 600; n++) begin
      bit rst, rdy, fl;
      if (!last_stall) begin
        ri        = $urandom;
        ri[6:0]   = ops[$urandom_range(0, 9)];
        ri[19:15] = 5'($urandom_range(0, 7));
        ri[24:20] = 5'($urandom_range(0, 7));
        ri[11:7]  = 5'($urandom_range(0, 7));
        rpc       = $urandom;
        rv        = ($urandom_range(0, 5) != 0);
      end
      rst = ($urandom_range(0, 99) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 11) == 0);
      cycle(rst, rv, ri, rpc, $urandom, $urandom, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 1) == 1, rdy, fl);
    end

    after_edge();
    after_edge();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
